mac_operand_fifo: RTL and testbench

//  Synchronous circular FIFO that buffers MAC operand words between the producer and the MAC datapath.

---
 rtl/mac_fifo_pkg.sv | 18 +
 rtl/mac_fifo_wrap_flag.sv | 29 ++
 rtl/mac_operand_fifo.sv | 108 ++++++++++
 tb/tb_mac_operand_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_fifo_pkg
// Brief   : Shared sizing constants and address helper for the MAC operand FIFO
// Revision: 1.0
// ============================================================================
package mac_fifo_pkg;

    localparam int c_BUFFER_WIDTH = 2;
    localparam int c_DATA_WIDTH   = 8;

    // Highest address of a pointer that is `width` bits wide (wrap point)
    function automatic int unsigned addr_all_ones(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : mac_fifo_pkg
`default_nettype wire

// File: rtl/mac_fifo_wrap_flag.sv
`default_nettype none
// ============================================================================
// Module  : mac_fifo_wrap_flag
// Brief   : Round flag; set while the write pointer is one lap ahead of read
// Revision: 1.0
// ============================================================================
module mac_fifo_wrap_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic i_w_wrap,
    input  logic i_r_wrap,
    output logic o_round
);

    logic r_round;

    // Simultaneous wraps cancel: both pointers moved a full lap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_round <= 1'b0;
        end else begin
            r_round <= r_round ^ i_w_wrap ^ i_r_wrap;
        end
    end

    assign o_round = r_round;

endmodule : mac_fifo_wrap_flag
`default_nettype wire

// File: rtl/mac_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mac_operand_fifo
// Brief   : Circular operand FIFO between producer and MAC, 1-cycle read
// Revision: 1.0
// ============================================================================
module mac_operand_fifo
    import mac_fifo_pkg::*;
#(
    parameter int BufferWidth = c_BUFFER_WIDTH,
    parameter int DataWidth   = c_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Push,
    input  logic [DataWidth-1:0]   W_Data,
    input  logic                   Pop,
    output logic [DataWidth-1:0]   R_Data,
    output logic                   R_Valid,
    output logic                   Full,
    output logic                   Empty,
    output logic [BufferWidth:0]   Level,
    output logic                   Ovf,
    output logic                   Udf
);

    localparam int                     c_DEPTH    = 1 << BufferWidth;
    localparam logic [BufferWidth-1:0] c_ADDR_MAX = BufferWidth'(addr_all_ones(BufferWidth));

    logic [DataWidth-1:0]   r_mem [c_DEPTH];
    logic [BufferWidth-1:0] r_w_addr;
    logic [BufferWidth-1:0] r_r_addr;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_rvalid;
    logic                   r_ovf;
    logic                   r_udf;

    logic w_round;
    logic w_same_addr;
    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_w_wrap;
    logic w_r_wrap;

    assign w_same_addr = (r_w_addr == r_r_addr);
    assign w_empty     = w_same_addr & ~w_round;
    assign w_full      = w_same_addr &  w_round;

    // A pop frees the slot first, so a push into a full FIFO is fine alongside it
    assign w_pop_ok  = Pop  & ~w_empty;
    assign w_push_ok = Push & (~w_full | w_pop_ok);

    assign w_w_wrap = w_push_ok & (r_w_addr == c_ADDR_MAX);
    assign w_r_wrap = w_pop_ok  & (r_r_addr == c_ADDR_MAX);

    mac_fifo_wrap_flag u_wrap_flag (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_w_wrap (w_w_wrap),
        .i_r_wrap (w_r_wrap),
        .o_round  (w_round)
    );

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_w_addr] <= W_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_addr <= '0;
            r_r_addr <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_rvalid <= w_pop_ok;
            if (w_push_ok) begin
                r_w_addr <= r_w_addr + BufferWidth'(1);
            end
            if (w_pop_ok) begin
                r_rdata  <= r_mem[r_r_addr];
                r_r_addr <= r_r_addr + BufferWidth'(1);
            end
            if (Push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (Pop && !w_pop_ok) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign R_Data  = r_rdata;
    assign R_Valid = r_rvalid;
    assign Full    = w_full;
    assign Empty   = w_empty;
    assign Level   = {w_round, r_w_addr} - {1'b0, r_r_addr};
    assign Ovf     = r_ovf;
    assign Udf     = r_udf;

endmodule : mac_operand_fifo
`default_nettype wire

// File: tb/tb_mac_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_operand_fifo
// Brief   : Directed, scoreboard-checked bench for mac_operand_fifo
// Revision: 1.0
// ============================================================================
module tb_mac_operand_fifo;

    localparam int c_BW    = 2;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 1 << c_BW;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            Push   = 1'b0;
    logic [c_DW-1:0] W_Data = '0;
    logic            Pop    = 1'b0;
    logic [c_DW-1:0] R_Data;
    logic            R_Valid;
    logic            Full;
    logic            Empty;
    logic [c_BW:0]   Level;
    logic            Ovf;
    logic            Udf;

    mac_operand_fifo #(
        .BufferWidth (c_BW),
        .DataWidth   (c_DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Push    (Push),
        .W_Data  (W_Data),
        .Pop     (Pop),
        .R_Data  (R_Data),
        .R_Valid (R_Valid),
        .Full    (Full),
        .Empty   (Empty),
        .Level   (Level),
        .Ovf     (Ovf),
        .Udf     (Udf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [c_DW-1:0] sb [$];
    int              m_level  = 0;
    logic            m_ovf    = 1'b0;
    logic            m_udf    = 1'b0;
    logic            m_rvalid = 1'b0;
    logic [c_DW-1:0] m_rdata  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Level"},   32'(Level),   32'(m_level));
        chk({tag, ".Full"},    32'(Full),    32'(m_level == c_DEPTH));
        chk({tag, ".Empty"},   32'(Empty),   32'(m_level == 0));
        chk({tag, ".Ovf"},     32'(Ovf),     32'(m_ovf));
        chk({tag, ".Udf"},     32'(Udf),     32'(m_udf));
        chk({tag, ".R_Valid"}, 32'(R_Valid), 32'(m_rvalid));
        chk({tag, ".R_Data"},  32'(R_Data),  32'(m_rdata));
    endtask

    task automatic model_reset();
        sb.delete();
        m_level  = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // One clock of stimulus; the scoreboard yields the word the DUT must return
    task automatic step(input bit push, input logic [c_DW-1:0] d, input bit pop);
        bit pop_ok;
        bit push_ok;
        Push    = push;
        W_Data  = d;
        Pop     = pop;
        pop_ok  = pop && (m_level != 0);
        push_ok = push && ((m_level != c_DEPTH) || pop_ok);
        @(posedge clk);
        #1;
        m_rvalid = pop_ok;
        if (pop_ok) begin
            m_rdata = sb.pop_front();
            m_level--;
        end
        if (push_ok) begin
            sb.push_back(d);
            m_level++;
        end
        if (push && !push_ok) m_ovf = 1'b1;
        if (pop && !pop_ok)   m_udf = 1'b1;
        Push = 1'b0;
        Pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [c_DW-1:0] v;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_all("reset");

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            v = 8'h11 * 8'(i + 1);
            step(1'b1, v, 1'b0);
            check_all("fill");
        end

        // Overflow attempt, then drain in order
        step(1'b1, 8'h99, 1'b0);
        check_all("ovf");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check_all("drain");
        end

        // Underflow, then push+pop while empty
        step(1'b0, 8'h00, 1'b1);
        check_all("udf");
        step(1'b1, 8'hA5, 1'b1);
        check_all("pushpop_empty");

        // Refill to full, simultaneous push+pop at full, drain
        for (int i = 0; i < 3; i++) begin
            v = 8'hB1 + 8'(i);
            step(1'b1, v, 1'b0);
            check_all("refill");
        end
        step(1'b1, 8'h55, 1'b1);
        check_all("full_pushpop");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check_all("drain2");
        end

        // Steady streaming at Level=1, pointers wrap repeatedly
        step(1'b1, 8'h60, 1'b0);
        check_all("stream_seed");
        for (int i = 0; i < 10; i++) begin
            v = 8'h61 + 8'(i);
            step(1'b1, v, 1'b1);
            check_all("stream");
        end

        // Reset mid-operation at Level=3 with Ovf set
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        check_all("pre_rst");
        do_reset();
        check_all("mid_rst");
        step(1'b1, 8'h77, 1'b0);
        check_all("post_rst_push");
        step(1'b0, 8'h00, 1'b1);
        check_all("post_rst_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mac_operand_fifo
`default_nettype wire
